// File: rtl/leg_perf_pkg.sv
// leg_perf_pkg: counter indices, register map and CTRL bit positions shared by the LEG performance monitor
package leg_perf_pkg;
    typedef enum logic [3:0] {
        CNT_CYCLES, CNT_INSTR, CNT_BRANCH, CNT_BR_TAKEN, CNT_ISTALL, CNT_DSTALL_EVT, CNT_DSTALL_CYC,
        CNT_LDRSTALL, CNT_PCSRCW, CNT_FLUSHD, CNT_FLUSHE, CNT_UOP, CNT_WASTED
    } cnt_e;
    localparam int NUM_CNT = 13;
    localparam logic [3:0] ADDR_CTRL = 4'd13;
    localparam logic [3:0] ADDR_OVF = 4'd14;
    localparam int CTRL_EN = 0;
    localparam int CTRL_CLR = 1;
    localparam int CTRL_IRQEN = 2;
endpackage

// File: rtl/leg_perf_cnt.sv
// leg_perf_cnt: one wrapping event counter with clear, software load and a wrap pulse
module leg_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    input  logic             clr_i,
    input  logic             ld_i,
    input  logic [CNT_W-1:0] ldval_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             wrap_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d  = clr_i ? '0 : ld_i ? ldval_i : inc_i ? cnt_q + CNT_W'(1) : cnt_q;
        wrap_o = inc_i & ~clr_i & ~ld_i & (&cnt_q);
    end
    always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
    assign cnt_o = cnt_q;
endmodule

// File: rtl/leg_perf_counters.sv
// leg_perf_counters: pipeline profiling counters behind a CP15-style register port.
// Define LEG_PERF_IRQ_EN to add CTRL.IRQEN and the overflow interrupt PerfIrq.
module leg_perf_counters
    import leg_perf_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] InstrE,
    input  logic        StallE,
    input  logic        StallD,
    input  logic        StalluOp,
    input  logic        BranchE,
    input  logic        BranchTakenE,
    input  logic        IStall,
    input  logic        DStall,
    input  logic        ldrStallD,
    input  logic        PCSrcW,
    input  logic        FlushD,
    input  logic        FlushE,
    input  logic [3:0]  RegAddr,
    input  logic        RegRE,
    input  logic        RegWE,
    input  logic [31:0] RegWD,
    output logic [31:0] RegRD,
    output logic        PerfIrq
);
    logic [31:0] instr_prev_q, rd_q, rd_d, rdata;
    logic istall_prev_q, dstall_prev_q, ldr_prev_q, pcsrc_prev_q;
    logic en_q, en_d, irqen_q, instr_evt, we_ctrl, we_ovf, clr;
    logic [NUM_CNT-1:0] ovf_q, ovf_d, evt, inc, ld, wrap;
    logic [CNT_W-1:0] cnt [NUM_CNT];

    always_comb begin
        instr_evt                   = (InstrE != instr_prev_q) && (InstrE != '0);
        evt                         = '0;
        evt[CNT_CYCLES]             = 1'b1;
        evt[CNT_INSTR]              = instr_evt;
        evt[CNT_BRANCH]             = instr_evt & BranchE;
        evt[CNT_BR_TAKEN]           = instr_evt & BranchTakenE;
        evt[CNT_ISTALL]             = IStall & ~istall_prev_q;
        evt[CNT_DSTALL_EVT]         = DStall & ~dstall_prev_q;
        evt[CNT_DSTALL_CYC]         = DStall;
        evt[CNT_LDRSTALL]           = ldrStallD & ~ldr_prev_q;
        evt[CNT_PCSRCW]             = PCSrcW & ~pcsrc_prev_q;
        evt[CNT_FLUSHD]             = FlushD;
        evt[CNT_FLUSHE]             = FlushE;
        evt[CNT_UOP]                = StallD & ~StalluOp;
        evt[CNT_WASTED]             = (InstrE == '0) | StallE;
        inc                         = en_q ? evt : '0;
        we_ctrl                     = RegWE && RegAddr == ADDR_CTRL;
        we_ovf                      = RegWE && RegAddr == ADDR_OVF;
        clr                         = we_ctrl & RegWD[CTRL_CLR];
        ld                          = '0;
        rdata                       = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            ld[i] = RegWE && RegAddr == 4'(i);
            if (RegAddr == 4'(i)) rdata = 32'(cnt[i]);
        end
        if (RegAddr == ADDR_CTRL) rdata = {29'd0, irqen_q, 1'b0, en_q};
        if (RegAddr == ADDR_OVF) rdata = 32'(ovf_q);
        // a wrap landing in the same cycle as a software clear keeps its sticky bit
        ovf_d = clr ? '0 : (ovf_q & ~(we_ovf ? RegWD[NUM_CNT-1:0] : '0)) | wrap;
        en_d  = we_ctrl ? RegWD[CTRL_EN] : en_q;
        rd_d  = RegRE ? rdata : rd_q;
    end

    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
        leg_perf_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk     (clk),
            .reset   (reset),
            .inc_i   (inc[g]),
            .clr_i   (clr),
            .ld_i    (ld[g]),
            .ldval_i (RegWD[CNT_W-1:0]),
            .cnt_o   (cnt[g]),
            .wrap_o  (wrap[g])
        );
    end

    // edge-detect history runs even while disabled so re-enabling never sees a stale edge
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_prev_q  <= '0;
            istall_prev_q <= 1'b0;
            dstall_prev_q <= 1'b0;
            ldr_prev_q    <= 1'b0;
            pcsrc_prev_q  <= 1'b0;
            en_q          <= 1'b1;
            ovf_q         <= '0;
            rd_q          <= '0;
        end else begin
            instr_prev_q  <= InstrE;
            istall_prev_q <= IStall;
            dstall_prev_q <= DStall;
            ldr_prev_q    <= ldrStallD;
            pcsrc_prev_q  <= PCSrcW;
            en_q          <= en_d;
            ovf_q         <= ovf_d;
            rd_q          <= rd_d;
        end
    end
    assign RegRD = rd_q;

`ifdef LEG_PERF_IRQ_EN
    logic irq_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            irqen_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            irqen_q <= we_ctrl ? RegWD[CTRL_IRQEN] : irqen_q;
            irq_q   <= irqen_q & (|ovf_q);
        end
    end
    assign PerfIrq = irq_q;
`else
    assign irqen_q = 1'b0;
    assign PerfIrq = 1'b0;
`endif
endmodule

// File: tb/tb_leg_perf_counters.sv
// tb_leg_perf_counters: directed tables plus randomized run against a cycle-level reference model
module tb_leg_perf_counters;
    localparam int W = 8;
`ifdef LEG_PERF_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif

    typedef struct {
        string       nm;
        logic [3:0]  addr;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic [31:0] InstrE, RegWD, RegRD;
    logic StallE, StallD, StalluOp, BranchE, BranchTakenE, IStall, DStall, ldrStallD, PCSrcW;
    logic FlushD, FlushE, RegRE, RegWE, PerfIrq;
    logic [3:0] RegAddr;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    leg_perf_counters #(.CNT_W(W)) dut (
        .clk(clk), .reset(reset), .InstrE(InstrE), .StallE(StallE), .StallD(StallD),
        .StalluOp(StalluOp), .BranchE(BranchE), .BranchTakenE(BranchTakenE), .IStall(IStall),
        .DStall(DStall), .ldrStallD(ldrStallD), .PCSrcW(PCSrcW), .FlushD(FlushD), .FlushE(FlushE),
        .RegAddr(RegAddr), .RegRE(RegRE), .RegWE(RegWE), .RegWD(RegWD), .RegRD(RegRD),
        .PerfIrq(PerfIrq)
    );

    int unsigned m_cnt[13];
    logic [12:0] m_ovf;
    logic [31:0] m_rd, m_iprev;
    logic m_en, m_irqen, m_irq, m_isp, m_dsp, m_lsp, m_psp;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // one clock of the register map described by the spec, applied to the current inputs
    task automatic model_step();
        logic [31:0] r;
        logic [12:0] e, wr;
        logic nw, clr;
        int unsigned mx;
        mx = (1 << W) - 1;
        if (reset) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_ovf = '0; m_rd = '0; m_iprev = '0; m_en = 1'b1; m_irqen = 1'b0; m_irq = 1'b0;
            m_isp = 1'b0; m_dsp = 1'b0; m_lsp = 1'b0; m_psp = 1'b0;
            return;
        end
        r = (RegAddr < 13) ? m_cnt[RegAddr] : (RegAddr == 13) ? {29'd0, m_irqen, 1'b0, m_en}
          : (RegAddr == 14) ? 32'(m_ovf) : 32'd0;
        if (RegRE) m_rd = r;
        nw  = InstrE != m_iprev && InstrE != 0;
        clr = RegWE && RegAddr == 13 && RegWD[1];
        e = {StallE | (InstrE == 0), StallD & ~StalluOp, FlushE, FlushD, PCSrcW & ~m_psp,
             ldrStallD & ~m_lsp, DStall, DStall & ~m_dsp, IStall & ~m_isp,
             nw & BranchTakenE, nw & BranchE, nw, 1'b1};
        m_irq = m_irqen & (|m_ovf);
        wr = '0;
        for (int i = 0; i < 13; i++) begin
            if (clr) m_cnt[i] = 0;
            else if (RegWE && RegAddr == 4'(i)) m_cnt[i] = RegWD & mx;
            else if (m_en && e[i]) begin
                wr[i] = m_cnt[i] == mx;
                m_cnt[i] = (m_cnt[i] + 1) % (mx + 1);
            end
        end
        m_ovf = clr ? 13'd0 : (m_ovf & ~((RegWE && RegAddr == 14) ? RegWD[12:0] : 13'd0)) | wr;
        if (RegWE && RegAddr == 13) begin
            m_en = RegWD[0];
            if (IRQ) m_irqen = RegWD[2];
        end
        m_iprev = InstrE; m_isp = IStall; m_dsp = DStall; m_lsp = ldrStallD; m_psp = PCSrcW;
    endtask

    task automatic cyc();
        model_step();
        @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        RegWE = 1'b1; RegAddr = a; RegWD = d;
        cyc();
        RegWE = 1'b0;
    endtask

    task automatic rdchk(input string nm, input logic [3:0] a, input logic [31:0] exp);
        RegRE = 1'b1; RegAddr = a;
        cyc();
        RegRE = 1'b0;
        chk(nm, RegRD, exp);
    endtask

    task automatic run_tab(input vec_t t[]);
        foreach (t[i]) rdchk(t[i].nm, t[i].addr, t[i].exp);
    endtask

    initial begin
        vec_t t1[], t2[];
        logic [31:0] seq[5];
        logic br[5];
        logic ds[9];
        t1 = '{'{"reset_cycles", 4'd0, 32'd10}, '{"reset_wasted", 4'd12, 32'd11},
               '{"reset_instr", 4'd1, 32'd0}, '{"reset_ctrl", 4'd13, 32'd1}};
        t2 = '{'{"seq_instr", 4'd1, 32'd3}, '{"seq_branch", 4'd2, 32'd1},
               '{"seq_taken", 4'd3, 32'd1}};
        seq = '{32'h11, 32'h11, 32'h22, 32'h0, 32'h33};
        br  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        ds  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        {InstrE, RegWD, RegAddr} = '0;
        {StallE, StallD, StalluOp, BranchE, BranchTakenE, IStall, DStall, ldrStallD, PCSrcW} = '0;
        {FlushD, FlushE, RegRE, RegWE} = '0;
        reset = 1'b1;
        RegRE = 1'b1;
        cyc(); cyc();
        chk("rd_in_reset", RegRD, 32'd0);
        chk("irq_in_reset", {31'd0, PerfIrq}, 32'd0);
        RegRE = 1'b0;
        reset = 1'b0;
        repeat (10) cyc();
        run_tab(t1);

        wr(4'd13, 32'd3);
        for (int k = 0; k < 5; k++) begin
            InstrE = seq[k]; BranchE = br[k]; BranchTakenE = br[k];
            cyc();
        end
        BranchE = 1'b0; BranchTakenE = 1'b0;
        run_tab(t2);

        wr(4'd13, 32'd3);
        foreach (ds[k]) begin
            DStall = ds[k];
            cyc();
        end
        rdchk("dstall_evt", 4'd5, 32'd2);
        rdchk("dstall_cyc", 4'd6, 32'd7);

        wr(4'd13, 32'd7);
        rdchk("ctrl_irqen", 4'd13, IRQ ? 32'd5 : 32'd1);
        wr(4'd1, 32'hFE);
        for (int k = 1; k <= 3; k++) begin
            InstrE = 32'h40 + 32'(k);
            cyc();
            chk($sformatf("irq_wrap_%0d", k), {31'd0, PerfIrq}, {31'd0, IRQ && k == 3});
        end
        rdchk("wrap_instr", 4'd1, 32'd1);
        rdchk("wrap_ovf", 4'd14, 32'd2);
        wr(4'd14, 32'd2);
        chk("irq_clear_cycle", {31'd0, PerfIrq}, {31'd0, IRQ});
        cyc();
        chk("irq_after_clear", {31'd0, PerfIrq}, 32'd0);
        rdchk("ovf_cleared", 4'd14, 32'd0);

        wr(4'd13, 32'd3);
        IStall = 1'b1;
        cyc();
        wr(4'd13, 32'd0);
        repeat (5) cyc();
        rdchk("frozen_cycles_a", 4'd0, 32'd2);
        repeat (3) cyc();
        rdchk("frozen_cycles_b", 4'd0, 32'd2);
        wr(4'd13, 32'd1);
        repeat (2) cyc();
        rdchk("istall_no_false_edge", 4'd4, 32'd1);
        IStall = 1'b0;
        wr(4'd13, 32'd2);
        rdchk("ctrl_after_clr", 4'd13, 32'd0);
        for (int a = 0; a < 13; a++) rdchk($sformatf("clr_cnt%0d", a), 4'(a), 32'd0);

        wr(4'd13, 32'd1);
        wr(4'd0, 32'd100);
        rdchk("load_beats_inc", 4'd0, 32'd100);
        RegRE = 1'b1; RegWE = 1'b1; RegAddr = 4'd0; RegWD = 32'd7;
        cyc();
        RegRE = 1'b0; RegWE = 1'b0;
        chk("read_pre_write", RegRD, 32'd101);
        rdchk("read_post_write", 4'd0, 32'd7);
        cyc();
        chk("rd_hold", RegRD, 32'd7);
        wr(4'd15, 32'hFFFF_FFFF);
        rdchk("reserved", 4'd15, 32'd0);

        for (int n = 0; n < 4000; n++) begin
            InstrE = $urandom_range(0, 3);
            {StallE, StallD, StalluOp, BranchE, BranchTakenE} = 5'($urandom);
            {IStall, DStall, ldrStallD, PCSrcW, FlushD, FlushE} = 6'($urandom);
            RegRE = 1'($urandom);
            RegWE = ($urandom_range(0, 7) == 0);
            RegAddr = 4'($urandom);
            RegWD = $urandom;
            if (RegAddr == 4'd13) RegWD[1:0] = {$urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0};
            reset = ($urandom_range(0, 499) == 0);
            cyc();
            chk("rand_rd", RegRD, m_rd);
            chk("rand_irq", {31'd0, PerfIrq}, {31'd0, m_irq});
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
